// File: rtl/mem_if_pkg.sv
// Shared types and constants for the CPU data-memory responder.
package mem_if_pkg;

  // Responder FSM state encoding
  typedef logic [1:0] memState_t;
  localparam memState_t IDLE = 2'd0;
  localparam memState_t WAIT = 2'd1;
  localparam memState_t RESP = 2'd2;

  // A doubleword is eight byte lanes wide
  localparam int DW_BYTES   = 8;
  localparam int BYTE_LANES = DW_BYTES;

  // One load/store request as presented by the CPU
  typedef struct packed {
    logic        write;
    logic        xferByte;
    logic [63:0] addr;
    logic [63:0] wdata;
  } memReq_t;

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage: eight byte-enabled write lanes and a
// combinational eight-byte read, both starting at a base index.
module mem_byte_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic                           clk,
  input  logic [BYTE_LANES-1:0]          wrEn,
  input  logic [$clog2(DEPTH_BYTES)-1:0] wrBase,
  input  logic [63:0]                    wrData,
  input  logic [$clog2(DEPTH_BYTES)-1:0] rdBase,
  output logic [63:0]                    rdData
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  logic [7:0] mem [DEPTH_BYTES];

  // Lane i writes byte i of wrData to wrBase+i (little-endian)
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (wrEn[i]) begin
        mem[wrBase + IDX_W'(i)] <= wrData[8*i +: 8];
      end
    end
  end

  // Lane gi reads the byte at rdBase+gi into bits [8*gi+7:8*gi]
  for (genvar gi = 0; gi < BYTE_LANES; gi++) begin : gReadLane
    assign rdData[8*gi +: 8] = mem[rdBase + IDX_W'(gi)];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store port. One request at a
// time; the response is committed when the FSM enters RESP and is held
// until the initiator takes it.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = $clog2(LATENCY + 1);

  memState_t             stateReg, stateNext;
  logic [CNT_W-1:0]      cntReg, cntNext;
  memReq_t               reqReg, curReq;
  logic                  commit;
  logic                  accessErr;
  logic [IDX_W-1:0]      memIdx;
  logic [BYTE_LANES-1:0] wrEn;
  logic [63:0]           rdData;
  logic [63:0]           rdataNext;

  assign req_ready = (stateReg == IDLE);
  assign rsp_valid = (stateReg == RESP);

  // With LATENCY=1 the commit edge is the acceptance edge, so the request
  // is taken straight from the port while idle; otherwise from the latch.
  always_comb begin
    curReq = reqReg;
    if (stateReg == IDLE) begin
      curReq.write    = req_write;
      curReq.xferByte = req_byte;
      curReq.addr     = req_addr;
      curReq.wdata    = req_wdata;
    end
  end

  // Range check on the full address before any truncation to an index
  always_comb begin
    accessErr = (curReq.addr >= 64'(DEPTH_BYTES)) ||
                (!curReq.xferByte && (curReq.addr[2:0] != 3'd0));
    memIdx    = curReq.addr[IDX_W-1:0];
  end

  // Next-state, latency counter and commit strobe
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    commit    = 1'b0;
    case (stateReg)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            stateNext = RESP;
            commit    = 1'b1;
          end else begin
            stateNext = WAIT;
            cntNext   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cntNext = cntReg - CNT_W'(1);
        if (cntReg == CNT_W'(1)) begin
          stateNext = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Store enables: only legal stores at the commit edge, never under reset
  always_comb begin
    wrEn = '0;
    if (commit && curReq.write && !accessErr && !reset) begin
      wrEn = curReq.xferByte ? {{(BYTE_LANES-1){1'b0}}, 1'b1} : '1;
    end
  end

  // Response data: zero for stores/errors, zero-extended for byte loads
  always_comb begin
    if (curReq.write || accessErr) begin
      rdataNext = '0;
    end else if (curReq.xferByte) begin
      rdataNext = {56'd0, rdData[7:0]};
    end else begin
      rdataNext = rdData;
    end
  end

  mem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) uMem (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrBase (memIdx),
    .wrData (curReq.wdata),
    .rdBase (memIdx),
    .rdData (rdData)
  );

  // FSM state, request latch and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg  <= IDLE;
      cntReg    <= '0;
      reqReg    <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (req_ready && req_valid) begin
        reqReg <= curReq;
      end
      if (commit) begin
        rsp_rdata <= rdataNext;
        rsp_error <= accessErr;
      end else if (rsp_valid && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_error <= 1'b0;
      end
    end
  end

endmodule
